html_char_plotter: RTL and testbench
====================================

# html_char_plotter

Parametrised character-to-pixel renderer between the HTML character stream and the VGA adapter's plot port. It accepts one character per valid/ready handshake, fetches the glyph rows from an external synchronous font ROM, and emits one pixel write per cycle at a hardware-tracked text cursor. It handles newline and carriage return, wraps at the right edge, and supports either a stop-when-full or a wrap-to-top mode. Its `char_ready` output drives the reader's pause input directly (pause = ~char_ready).

## Interface
- `X_W`, 9: pixel x width.
- `Y_W`, 8: pixel y width.
- `COLOR_W`, 3: colour width.
- `CHAR_W`, 8: character code width.
- `SCREEN_W`, 320: screen width in pixels.
- `SCREEN_H`, 240: screen height in pixels.
- `GLYPH_W`, 8: glyph width in pixels; also the width of a ROM row.
- `GLYPH_H`, 8: glyph height in pixels (rows per glyph).
- `WRAP_MODE`, 0: behaviour when the screen is full. 0 = stop; 1 = wrap to the top line.

Ports:
- `CLOCK_50` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `char_in` in CHAR_W: character code.
- `char_valid` in 1: `char_in` is valid.
- `char_ready` out 1: the block will accept `char_in` this cycle.
- `fg_colour` in COLOR_W: colour for glyph pixels that are 1. Sampled at accept.
- `bg_colour` in COLOR_W: colour for glyph pixels that are 0. Sampled at accept.
- `glyph_addr` out CHAR_W+clog2(GLYPH_H): font ROM address, {char, row}.
- `glyph_row` in GLYPH_W: ROM data, valid the cycle after `glyph_addr`. Bit GLYPH_W-1 is the leftmost pixel.
- `x` out X_W: pixel x.
- `y` out Y_W: pixel y.
- `colour` out COLOR_W: pixel colour.
- `plot` out 1: write enable to the VGA adapter.
- `full` out 1: screen exhausted (WRAP_MODE=0 only).

## Operation
States: IDLE, FETCH, LOAD, PLOT, FULL.
- **IDLE**
  - `char_ready`=1.
  - On `char_valid`&`char_ready`, decode the character:
    - 0x0A: cur_x←0, cur_y←cur_y+GLYPH_H. Stay in IDLE.
    - 0x0D: cur_x←0. Stay in IDLE.
    - 0x20–0x7E: latch the character and both colours; row←0; go to FETCH.
    - Any other code: consumed and discarded, no plot. Stay in IDLE.
- **FETCH**
  - Drive `glyph_addr`={char,row}.
  - Go to LOAD.
- **LOAD**
  - Shift register ← `glyph_row`; col←0.
  - Go to PLOT.
- **PLOT**
  - `plot`=1, `x`=cur_x+col, `y`=cur_y+row.
  - `colour` = shift MSB ? fg : bg.
  - Shift left; col++.
  - After col=GLYPH_W-1:
    - If row<GLYPH_H-1: row++ and go to FETCH.
    - Otherwise: advance the cursor and go to IDLE.
- **Cursor advance after a glyph**
  - cur_x←cur_x+GLYPH_W.
  - If cur_x+2·GLYPH_W > SCREEN_W, then instead cur_x←0 and cur_y←cur_y+GLYPH_H.
- **Line overflow check** (after any cur_y increment, from the advance or from 0x0A)
  - Overflow means new cur_y+GLYPH_H > SCREEN_H.
  - WRAP_MODE=1: cur_y←0.
  - WRAP_MODE=0: go to FULL.
- **FULL**
  - `full`=1, `char_ready`=1.
  - All characters are consumed and discarded; no plots.
  - Exits only via reset.
- **Arithmetic**
  - Cursor registers are X_W/Y_W bits wide and never exceed the screen bounds.
  - Outputs `x`/`y` never reach ≥SCREEN_W or ≥SCREEN_H.
- **Outputs during non-PLOT states**
  - `plot`=0.
  - `x`/`y`/`colour` hold their last values (don't-care to the VGA adapter).

## Timing
- **Reset values:**
  - State IDLE.
  - `char_ready`=0 while `reset` is high, then 1 in the first cycle after reset.
  - `plot`=0, `x`=0, `y`=0, `colour`=0, `full`=0, `glyph_addr`=0.
  - cur_x=cur_y=0.
- **Reset mid-glyph:**
  - Aborts on the next edge; `plot`=0 from then on.
  - No partial completion and no cursor advance.
- **Glyph timing** (glyph accepted at edge k):
  - Per row: 1 FETCH + 1 LOAD + GLYPH_W PLOT cycles.
  - Glyph cost: GLYPH_H·(GLYPH_W+2) cycles; 80 cycles for 8×8.
  - `char_ready`=0 from cycle k+1 through k+80.
  - `char_ready`=1 at cycle k+81.
- **First pixel:** `plot`=1 at cycle k+3; each row's first pixel is the leftmost.
- **Control and discarded characters:** accepted at 1 per cycle; `char_ready` stays high.
- **Handshake:** `char_ready` is registered. It does not depend combinationally on `char_valid`.
- **Sampling:** colours are sampled only at accept; changing `fg_colour`/`bg_colour` mid-glyph has no effect.

## Test plan
- Reset, then send 'A' (0x41) with fg=3'b100, bg=3'b111 at cursor (0,0); the ROM model returns a known pattern.
  - Expect exactly 64 `plot` pulses covering x 0–7, y 0–7.
  - Each colour matches its ROM bit.
  - `char_ready` low for 80 cycles.
- Send 40 printable characters (SCREEN_W=320).
  - The 40th is drawn at x=312.
  - The 41st is drawn at (0,8).
- Send "AB", 0x0D, "C".
  - 'C' overwrites 'A' at (0,0).
- Send 0x0A, then "X".
  - 'X' is drawn at (0,8); the newline costs 1 cycle with `char_ready` held high.
  - Send 0x07: it is consumed in 1 cycle with no plot.
- WRAP_MODE=0, 30 newlines.
  - `full`=1 and stays 1.
  - A subsequent 'A' produces no plots and `char_ready` stays 1.
  - With WRAP_MODE=1 the same sequence leaves cur_y=0 and 'A' is drawn at (0,0).
- Assert `reset` at PLOT cycle 20 of a glyph.
  - `plot`=0 from the next cycle.
  - The next character is drawn at (0,0).
  - Check x<SCREEN_W and y<SCREEN_H on every plot throughout.

Source files
------------

// File: rtl/html_char_plotter.sv
// Character-to-pixel renderer: takes one character per handshake, reads glyph rows
// from a synchronous font ROM and emits one pixel write per cycle at a text cursor.
module html_char_plotter #(
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int COLOR_W   = 3,
    parameter int CHAR_W    = 8,
    parameter int SCREEN_W  = 320,
    parameter int SCREEN_H  = 240,
    parameter int GLYPH_W   = 8,
    parameter int GLYPH_H   = 8,
    parameter int WRAP_MODE = 0
) (
    input  logic                                CLOCK_50,
    input  logic                                reset,
    input  logic [CHAR_W-1:0]                   char_in,
    input  logic                                char_valid,
    output logic                                char_ready,
    input  logic [COLOR_W-1:0]                  fg_colour,
    input  logic [COLOR_W-1:0]                  bg_colour,
    output logic [CHAR_W+$clog2(GLYPH_H)-1:0]   glyph_addr,
    input  logic [GLYPH_W-1:0]                  glyph_row,
    output logic [X_W-1:0]                      x,
    output logic [Y_W-1:0]                      y,
    output logic [COLOR_W-1:0]                  colour,
    output logic                                plot,
    output logic                                full
);

    localparam int ROW_W = $clog2(GLYPH_H);
    localparam int COL_W = $clog2(GLYPH_W);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(GLYPH_H - 1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(GLYPH_W - 1);
    localparam logic [CHAR_W-1:0] CODE_LF  = CHAR_W'(8'h0A);
    localparam logic [CHAR_W-1:0] CODE_CR  = CHAR_W'(8'h0D);
    localparam logic [CHAR_W-1:0] CODE_LO  = CHAR_W'(8'h20);
    localparam logic [CHAR_W-1:0] CODE_HI  = CHAR_W'(8'h7E);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLOT, FULL} state_t;

    state_t               state;
    state_t               next_state;
    logic [X_W-1:0]       cur_x;
    logic [Y_W-1:0]       cur_y;
    logic [X_W-1:0]       next_cur_x;
    logic [Y_W-1:0]       next_cur_y;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     col;
    logic [CHAR_W-1:0]    ch;
    logic [COLOR_W-1:0]   fg;
    logic [COLOR_W-1:0]   bg;
    logic [GLYPH_W-1:0]   shift;
    logic [X_W-1:0]       last_x;
    logic [Y_W-1:0]       last_y;
    logic [COLOR_W-1:0]   last_colour;
    logic                 accept;
    logic                 printable;
    logic                 line_feed;
    logic                 wrap_x;
    logic                 y_overflow;
    logic [X_W-1:0]       pixel_x;
    logic [Y_W-1:0]       pixel_y;
    logic [COLOR_W-1:0]   pixel_colour;

    assign accept       = char_valid && char_ready;
    assign printable    = (char_in >= CODE_LO) && (char_in <= CODE_HI);
    assign wrap_x       = (int'(cur_x) + 2 * GLYPH_W) > SCREEN_W;
    assign y_overflow   = (int'(cur_y) + 2 * GLYPH_H) > SCREEN_H;
    assign pixel_x      = cur_x + X_W'(col);
    assign pixel_y      = cur_y + Y_W'(row);
    assign pixel_colour = shift[GLYPH_W-1] ? fg : bg;

    assign plot       = (state == PLOT);
    assign full       = (state == FULL);
    assign glyph_addr = {ch, row};
    assign x          = plot ? pixel_x : last_x;
    assign y          = plot ? pixel_y : last_y;
    assign colour     = plot ? pixel_colour : last_colour;

    always_comb begin
        next_state = state;
        next_cur_x = cur_x;
        next_cur_y = cur_y;
        line_feed  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (char_in == CODE_LF) begin
                        next_cur_x = '0;
                        line_feed  = 1'b1;
                    end else if (char_in == CODE_CR) begin
                        next_cur_x = '0;
                    end else if (printable) begin
                        next_state = FETCH;
                    end
                end
            end
            FETCH: next_state = LOAD;
            LOAD:  next_state = PLOT;
            PLOT: begin
                if (col == LAST_COL) begin
                    if (row != LAST_ROW) begin
                        next_state = FETCH;
                    end else begin
                        next_state = IDLE;
                        if (wrap_x) begin
                            next_cur_x = '0;
                            line_feed  = 1'b1;
                        end else begin
                            next_cur_x = cur_x + X_W'(GLYPH_W);
                        end
                    end
                end
            end
            FULL:    next_state = FULL;
            default: next_state = IDLE;
        endcase
        // A line feed that would push the next text line past the bottom either
        // wraps to the top or freezes the plotter, depending on WRAP_MODE.
        if (line_feed) begin
            if (y_overflow) begin
                if (WRAP_MODE != 0) begin
                    next_cur_y = '0;
                end else begin
                    next_state = FULL;
                end
            end else begin
                next_cur_y = cur_y + Y_W'(GLYPH_H);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            cur_x       <= '0;
            cur_y       <= '0;
            row         <= '0;
            col         <= '0;
            ch          <= '0;
            fg          <= '0;
            bg          <= '0;
            shift       <= '0;
            last_x      <= '0;
            last_y      <= '0;
            last_colour <= '0;
            char_ready  <= 1'b0;
        end else begin
            state      <= next_state;
            cur_x      <= next_cur_x;
            cur_y      <= next_cur_y;
            char_ready <= (next_state == IDLE) || (next_state == FULL);
            case (state)
                IDLE: begin
                    if (accept && printable) begin
                        ch  <= char_in;
                        fg  <= fg_colour;
                        bg  <= bg_colour;
                        row <= '0;
                    end
                end
                LOAD: begin
                    shift <= glyph_row;
                    col   <= '0;
                end
                PLOT: begin
                    shift       <= shift << 1;
                    col         <= col + 1'b1;
                    last_x      <= pixel_x;
                    last_y      <= pixel_y;
                    last_colour <= pixel_colour;
                    if (col == LAST_COL && row != LAST_ROW) begin
                        row <= row + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_html_char_plotter.sv
// Directed bench for html_char_plotter: a stop-mode and a wrap-mode instance,
// each with its own font ROM model and pixel capture queue.
module tb_html_char_plotter;

    typedef struct {
        int px;
        int py;
        int pc;
    } pix_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  char_in = 8'h00;
    logic        valid0 = 1'b0;
    logic        valid1 = 1'b0;
    logic [2:0]  fg = 3'd0;
    logic [2:0]  bg = 3'd0;

    logic        ready0, ready1;
    logic [10:0] glyph_addr0, glyph_addr1;
    logic [7:0]  glyph_row0, glyph_row1;
    logic [8:0]  x0, x1;
    logic [7:0]  y0, y1;
    logic [2:0]  colour0, colour1;
    logic        plot0, plot1;
    logic        full0, full1;

    int total = 0;
    int bad = 0;
    pix_t q0[$];
    pix_t q1[$];

    always #5 clock = ~clock;

    html_char_plotter dut0 (
        .CLOCK_50(clock), .reset(reset), .char_in(char_in), .char_valid(valid0),
        .char_ready(ready0), .fg_colour(fg), .bg_colour(bg), .glyph_addr(glyph_addr0),
        .glyph_row(glyph_row0), .x(x0), .y(y0), .colour(colour0), .plot(plot0), .full(full0)
    );

    html_char_plotter #(.WRAP_MODE(1)) dut1 (
        .CLOCK_50(clock), .reset(reset), .char_in(char_in), .char_valid(valid1),
        .char_ready(ready1), .fg_colour(fg), .bg_colour(bg), .glyph_addr(glyph_addr1),
        .glyph_row(glyph_row1), .x(x1), .y(y1), .colour(colour1), .plot(plot1), .full(full1)
    );

    function automatic logic [7:0] rom_row(input logic [7:0] c, input logic [2:0] r);
        return c ^ {r, r, r[2:1]} ^ 8'h3C;
    endfunction

    always @(posedge clock) begin
        glyph_row0 <= rom_row(glyph_addr0[10:3], glyph_addr0[2:0]);
        glyph_row1 <= rom_row(glyph_addr1[10:3], glyph_addr1[2:0]);
    end

    // Capture every pixel write and bound-check it on the opposite edge.
    always @(negedge clock) begin
        if (plot0) begin
            q0.push_back('{int'(x0), int'(y0), int'(colour0)});
            total++;
            assert (x0 < 9'd320 && y0 < 8'd240) else begin
                bad++;
                $error("FAIL bounds0 observed x=%0d y=%0d required x<320 y<240", x0, y0);
            end
        end
        if (plot1) begin
            q1.push_back('{int'(x1), int'(y1), int'(colour1)});
            total++;
            assert (x1 < 9'd320 && y1 < 8'd240) else begin
                bad++;
                $error("FAIL bounds1 observed x=%0d y=%0d required x<320 y<240", x1, y1);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string tag, input bit d0, input bit d1);
        int n = 0;
        while (((d0 && !ready0) || (d1 && !ready1)) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check(tag, n, 0);
    endtask

    // Present one character for exactly one accepting edge; returns one cycle after accept.
    task automatic send(input logic [7:0] c, input logic [2:0] f, input logic [2:0] b,
                        input bit d0, input bit d1);
        wait_ready("send_timeout", d0, d1);
        char_in = c;
        fg      = f;
        bg      = b;
        valid0  = d0;
        valid1  = d1;
        tick();
        valid0  = 1'b0;
        valid1  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        q0.delete();
        q1.delete();
    endtask

    task automatic check_glyph(input string tag, input int sel, input int base, input logic [7:0] c,
                               input int gx, input int gy, input logic [2:0] f, input logic [2:0] b);
        int errs = 0;
        int idx;
        pix_t e;
        logic [7:0] t;
        logic [2:0] expc;
        for (int r = 0; r < 8; r++) begin
            t = rom_row(c, r[2:0]);
            for (int k = 0; k < 8; k++) begin
                idx  = base + r * 8 + k;
                expc = t[7-k] ? f : b;
                if (idx >= (sel == 1 ? q1.size() : q0.size())) begin
                    errs++;
                end else begin
                    e = (sel == 1) ? q1[idx] : q0[idx];
                    if (e.px != gx + k || e.py != gy + r || e.pc != int'(expc)) errs++;
                end
            end
        end
        check(tag, errs, 0);
    endtask

    initial begin
        int low_cnt;
        int first_ready;
        int first_plot;
        int qs;
        int pcount;
        int n;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst_ready", int'(ready0), 0);
        check("rst_plot", int'(plot0), 0);
        check("rst_xy", int'(x0) + int'(y0), 0);
        check("rst_colour", int'(colour0), 0);
        check("rst_full", int'(full0), 0);
        check("rst_addr", int'(glyph_addr0), 0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", int'(ready0), 1);
        q0.delete();

        // Single glyph 'A' with timing; colours changed mid-glyph must not matter
        send(8'h41, 3'b100, 3'b111, 1'b1, 1'b0);
        low_cnt = 0;
        first_ready = 0;
        first_plot = 0;
        for (int c = 1; c <= 81; c++) begin
            if (c == 10) begin
                fg = 3'b001;
                bg = 3'b010;
            end
            if (!ready0) low_cnt++;
            else if (first_ready == 0) first_ready = c;
            if (plot0 && first_plot == 0) first_plot = c;
            tick();
        end
        check("a_ready_low", low_cnt, 80);
        check("a_ready_back", first_ready, 81);
        check("a_first_plot", first_plot, 3);
        check("a_count", q0.size(), 64);
        check_glyph("a_pixels", 0, 0, 8'h41, 0, 0, 3'b100, 3'b111);

        // 41 characters across a full line
        do_reset();
        for (int i = 0; i < 41; i++) send(8'h30 + 8'(i % 40), 3'd2, 3'd5, 1'b1, 1'b0);
        wait_ready("line_idle", 1'b1, 1'b0);
        check("line_count", q0.size(), 41 * 64);
        check_glyph("line_40th", 0, 39 * 64, 8'h30 + 8'd39, 312, 0, 3'd2, 3'd5);
        check_glyph("line_41st", 0, 40 * 64, 8'h30, 0, 8, 3'd2, 3'd5);

        // "AB", CR, "C" overwrites 'A'
        do_reset();
        send(8'h41, 3'd1, 3'd0, 1'b1, 1'b0);
        send(8'h42, 3'd1, 3'd0, 1'b1, 1'b0);
        send(8'h0D, 3'd1, 3'd0, 1'b1, 1'b0);
        send(8'h43, 3'd6, 3'd3, 1'b1, 1'b0);
        wait_ready("cr_idle", 1'b1, 1'b0);
        check_glyph("cr_c", 0, 128, 8'h43, 0, 0, 3'd6, 3'd3);

        // Newline then 'X' at (0,8); newline holds ready high
        send(8'h0A, 3'd0, 3'd0, 1'b1, 1'b0);
        check("nl_ready", int'(ready0), 1);
        send(8'h58, 3'd7, 3'd1, 1'b1, 1'b0);
        wait_ready("nl_idle", 1'b1, 1'b0);
        check_glyph("nl_x", 0, 192, 8'h58, 0, 8, 3'd7, 3'd1);

        // BEL is discarded without plots or cursor movement
        qs = q0.size();
        send(8'h07, 3'd7, 3'd7, 1'b1, 1'b0);
        check("bel_ready", int'(ready0), 1);
        for (int c = 0; c < 12; c++) tick();
        check("bel_noplot", q0.size(), qs);
        send(8'h44, 3'd4, 3'd2, 1'b1, 1'b0);
        wait_ready("bel_idle", 1'b1, 1'b0);
        check_glyph("bel_next", 0, 256, 8'h44, 8, 8, 3'd4, 3'd2);

        // 30 newlines: stop mode goes full, wrap mode returns to the top
        do_reset();
        for (int i = 0; i < 29; i++) send(8'h0A, 3'd0, 3'd0, 1'b1, 1'b1);
        check("full_before", int'(full0), 0);
        send(8'h0A, 3'd0, 3'd0, 1'b1, 1'b1);
        check("full_set", int'(full0), 1);
        check("full_ready", int'(ready0), 1);
        check("wrap_not_full", int'(full1), 0);
        qs = q0.size();
        send(8'h41, 3'd5, 3'd2, 1'b1, 1'b1);
        low_cnt = 0;
        n = 0;
        for (int c = 0; c < 85; c++) begin
            if (!ready0) low_cnt++;
            if (!full0) n++;
            tick();
        end
        check("full_ready_stays", low_cnt, 0);
        check("full_stays", n, 0);
        check("full_noplot", q0.size(), qs);
        wait_ready("wrap_idle", 1'b0, 1'b1);
        check_glyph("wrap_a", 1, 0, 8'h41, 0, 0, 3'd5, 3'd2);

        // Reset during the 20th plot cycle of a glyph
        do_reset();
        send(8'h41, 3'd2, 3'd5, 1'b1, 1'b0);
        pcount = 0;
        n = 0;
        while (pcount < 20 && n < 200) begin
            if (plot0) pcount++;
            if (pcount < 20) begin
                tick();
                n++;
            end
        end
        check("mid_reach20", pcount, 20);
        reset = 1'b1;
        tick();
        check("mid_plot0", int'(plot0), 0);
        check("mid_ready0", int'(ready0), 0);
        tick();
        check("mid_plot1", int'(plot0), 0);
        reset = 1'b0;
        tick();
        check("mid_ready_back", int'(ready0), 1);
        q0.delete();
        send(8'h42, 3'd3, 3'd6, 1'b1, 1'b0);
        wait_ready("mid_idle", 1'b1, 1'b0);
        check("mid_count", q0.size(), 64);
        check_glyph("mid_b", 0, 0, 8'h42, 0, 0, 3'd3, 3'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
